// File: rtl/dmem_arb_pkg.sv
// Shared definitions for the data-memory arbiter: FSM encoding, defaults, requester ids.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StBusy = 2'd1,
        StDone = 2'd2
    } arb_state_e;

    localparam int unsigned TIMEOUT_CYC_DEF = 15;

    // Requester slot indices within the packed request vectors
    localparam int unsigned CPU_ID = 0;
    localparam int unsigned LDR_ID = 1;

endpackage

// File: rtl/arb_rr2.sv
// Two-way round-robin pick: a lone requester wins, on conflict the one not served last wins.
module arb_rr2 (
    input  logic [1:0] req,
    input  logic       lp,
    output logic       winner
);

    // Combinational winner select; req == 0 yields a don't-care index of 0
    always_comb begin
        winner = 1'b0;
        case (req)
            2'b01:   winner = 1'b0;
            2'b10:   winner = 1'b1;
            2'b11:   winner = ~lp;
            default: winner = 1'b0;
        endcase
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one data memory between the CPU and a loader/debug port.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W      = 32,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                clk_in,
    input  logic                reset,
    input  logic [1:0]          req,
    input  logic [1:0]          we,
    input  logic [2*ADDR_W-1:0] addr,
    input  logic [2*DATA_W-1:0] wdata,
    output logic [1:0]          gnt,
    output logic [1:0]          rvalid,
    output logic [DATA_W-1:0]   rdata,
    output logic                mem_en,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata,
    input  logic                mem_ready,
    output logic                timeout_err
);

    localparam int unsigned CntW = $clog2(TIMEOUT_CYC + 1);
    // Counter value during the last permitted BUSY cycle (counter starts at 0)
    localparam logic [CntW-1:0] CntLast = CntW'(TIMEOUT_CYC - 1);

    arb_state_e          state_q, state_d;
    logic                lp_q, lp_d;
    logic                owner_q, owner_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic [1:0]          gnt_q, gnt_d;
    logic [1:0]          rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                mem_en_q, mem_en_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                timeout_err_q, timeout_err_d;
    logic                winner;

    logic [ADDR_W-1:0]   addr_arr  [2];
    logic [DATA_W-1:0]   wdata_arr [2];

    assign addr_arr[CPU_ID]  = addr[CPU_ID*ADDR_W +: ADDR_W];
    assign addr_arr[LDR_ID]  = addr[LDR_ID*ADDR_W +: ADDR_W];
    assign wdata_arr[CPU_ID] = wdata[CPU_ID*DATA_W +: DATA_W];
    assign wdata_arr[LDR_ID] = wdata[LDR_ID*DATA_W +: DATA_W];

    arb_rr2 u_arb (
        .req    (req),
        .lp     (lp_q),
        .winner (winner)
    );

    // Next-state and registered-output logic for IDLE -> BUSY -> DONE
    always_comb begin
        state_d       = state_q;
        lp_d          = lp_q;
        owner_d       = owner_q;
        cnt_d         = cnt_q;
        gnt_d         = 2'b00;
        rvalid_d      = 2'b00;
        rdata_d       = '0;
        mem_en_d      = mem_en_q;
        mem_we_d      = mem_we_q;
        mem_addr_d    = mem_addr_q;
        mem_wdata_d   = mem_wdata_q;
        timeout_err_d = timeout_err_q;
        unique case (state_q)
            StIdle: begin
                if (req != 2'b00) begin
                    owner_d        = winner;
                    mem_we_d       = we[winner];
                    mem_addr_d     = addr_arr[winner];
                    mem_wdata_d    = wdata_arr[winner];
                    gnt_d[winner]  = 1'b1;
                    mem_en_d       = 1'b1;
                    cnt_d          = '0;
                    state_d        = StBusy;
                end
            end
            StBusy: begin
                // A response on the last permitted cycle still completes normally
                if (mem_ready) begin
                    rdata_d          = mem_we_q ? '0 : mem_rdata;
                    rvalid_d[owner_q] = 1'b1;
                    mem_en_d         = 1'b0;
                    state_d          = StDone;
                end else if (cnt_q == CntLast) begin
                    rvalid_d[owner_q] = 1'b1;
                    timeout_err_d    = 1'b1;
                    mem_en_d         = 1'b0;
                    state_d          = StDone;
                end else begin
                    cnt_d = cnt_q + CntW'(1);
                end
            end
            StDone: begin
                lp_d    = owner_q;
                state_d = StIdle;
            end
            default: begin
                mem_en_d = 1'b0;
                state_d  = StIdle;
            end
        endcase
    end

    // State and output registers; reset clears everything and favours the CPU
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q       <= StIdle;
            lp_q          <= 1'b1;
            owner_q       <= 1'b0;
            cnt_q         <= '0;
            gnt_q         <= 2'b00;
            rvalid_q      <= 2'b00;
            rdata_q       <= '0;
            mem_en_q      <= 1'b0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            lp_q          <= lp_d;
            owner_q       <= owner_d;
            cnt_q         <= cnt_d;
            gnt_q         <= gnt_d;
            rvalid_q      <= rvalid_d;
            rdata_q       <= rdata_d;
            mem_en_q      <= mem_en_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_wdata_q   <= mem_wdata_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign gnt         = gnt_q;
    assign rvalid      = rvalid_q;
    assign rdata       = rdata_q;
    assign mem_en      = mem_en_q;
    assign mem_we      = mem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: transaction-level model plus directed scenarios.
module tb_dmem_arbiter;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned TO = 15;

    logic          clk_in    = 1'b0;
    logic          reset     = 1'b1;
    logic [1:0]    req       = 2'b00;
    logic [1:0]    we        = 2'b00;
    logic [2*AW-1:0] addr    = '0;
    logic [2*DW-1:0] wdata   = '0;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic [1:0]    gnt;
    logic [1:0]    rvalid;
    logic [DW-1:0] rdata;
    logic          mem_en;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          timeout_err;

    int   checks   = 0;
    int   failures = 0;
    logic cmp_en   = 1'b0;

    dmem_arbiter #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .req         (req),
        .we          (we),
        .addr        (addr),
        .wdata       (wdata),
        .gnt         (gnt),
        .rvalid      (rvalid),
        .rdata       (rdata),
        .mem_en      (mem_en),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_ready   (mem_ready),
        .timeout_err (timeout_err)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick();
        tick();
        reset = 1'b1;
    endtask

    // Lone requester wins; on conflict the one that was not served last wins
    function automatic logic pick(input logic [1:0] r, input logic last);
        if (r == 2'b01) return 1'b0;
        if (r == 2'b10) return 1'b1;
        return ~last;
    endfunction

    function automatic logic [1:0] onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

    // Transaction model: one outstanding access, numbered BUSY cycles, completion record
    logic          m_active, m_done, m_write, m_owner, m_lp, m_err;
    int            m_busy;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_rdata;

    always @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            m_active <= 1'b0;
            m_done   <= 1'b0;
            m_write  <= 1'b0;
            m_owner  <= 1'b0;
            m_lp     <= 1'b1;
            m_err    <= 1'b0;
            m_busy   <= 0;
            m_addr   <= '0;
            m_wdata  <= '0;
            m_rdata  <= '0;
        end else if (!m_active) begin
            if (req != 2'b00) begin
                m_active <= 1'b1;
                m_done   <= 1'b0;
                m_busy   <= 1;
                m_owner  <= pick(req, m_lp);
                m_write  <= we[pick(req, m_lp)];
                m_addr   <= pick(req, m_lp) ? addr[2*AW-1:AW] : addr[AW-1:0];
                m_wdata  <= pick(req, m_lp) ? wdata[2*DW-1:DW] : wdata[DW-1:0];
            end
        end else if (!m_done) begin
            if (mem_ready) begin
                m_done  <= 1'b1;
                m_rdata <= m_write ? '0 : mem_rdata;
            end else if (m_busy == int'(TO)) begin
                m_done  <= 1'b1;
                m_rdata <= '0;
                m_err   <= 1'b1;
            end else begin
                m_busy <= m_busy + 1;
            end
        end else begin
            m_lp     <= m_owner;
            m_active <= 1'b0;
            m_done   <= 1'b0;
        end
    end

    // Compare DUT against the model mid-cycle
    always @(negedge clk_in) begin
        if (cmp_en) begin
            chk("m_gnt", gnt, (m_active && !m_done && m_busy == 1) ? onehot(m_owner) : 2'b00);
            chk("m_mem_en", mem_en, m_active && !m_done);
            chk("m_rvalid", rvalid, (m_active && m_done) ? onehot(m_owner) : 2'b00);
            chk("m_timeout_err", timeout_err, m_err);
            if (m_active && !m_done) begin
                chk("m_mem_we", mem_we, m_write);
                chk("m_mem_addr", mem_addr, m_addr);
                chk("m_mem_wdata", mem_wdata, m_wdata);
            end
            if (m_active && m_done) chk("m_rdata", rdata, m_rdata);
        end
    end

    logic [1:0] g_seen [9];
    logic [1:0] g_exp  [9] = '{2'b01, 2'b00, 2'b00, 2'b10, 2'b00, 2'b00, 2'b01, 2'b00, 2'b00};
    int         busy_cnt;
    logic       seen;

    initial begin
        // Reset state
        #2 reset = 1'b0;
        #1 cmp_en = 1'b1;
        #1;
        chk("rst_gnt", gnt, 2'b00);
        chk("rst_rvalid", rvalid, 2'b00);
        chk("rst_mem_en", mem_en, 1'b0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_timeout_err", timeout_err, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        tick();

        // Both requesting with zero-wait memory: CPU, loader, CPU every 3 cycles
        addr      = {32'h0000_0200, 32'h0000_0100};
        req       = 2'b11;
        mem_ready = 1'b1;
        for (int i = 0; i < 9; i++) begin
            tick();
            g_seen[i] = gnt;
        end
        req       = 2'b00;
        mem_ready = 1'b0;
        for (int i = 0; i < 9; i++) chk($sformatf("rr_gnt_%0d", i), g_seen[i], g_exp[i]);
        tick();

        // CPU read at 0x10, ready on the second BUSY cycle
        addr      = {32'h0000_0999, 32'h0000_0010};
        we        = 2'b00;
        mem_rdata = 32'h1234_ABCD;
        req       = 2'b01;
        tick();
        chk("rd_gnt", gnt, 2'b01);
        chk("rd_mem_addr", mem_addr, 32'h10);
        req = 2'b00;
        tick();
        chk("rd_gnt_once", gnt, 2'b00);
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rd_rvalid", rvalid, 2'b01);
        chk("rd_rdata", rdata, 32'h1234_ABCD);
        tick();
        chk("rd_rvalid_once", rvalid, 2'b00);

        // Loader write 0x40 / 0xCAFE0001, fields held while inputs change
        addr      = {32'h0000_0040, 32'h0000_0777};
        wdata     = {32'hCAFE_0001, 32'h5555_5555};
        we        = 2'b10;
        mem_rdata = 32'hDEAD_BEEF;
        req       = 2'b10;
        tick();
        chk("wr_gnt", gnt, 2'b10);
        req   = 2'b00;
        we    = 2'b00;
        addr  = '1;
        wdata = '0;
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("wr_mem_we", mem_we, 1'b1);
            chk("wr_mem_addr", mem_addr, 32'h40);
            chk("wr_mem_wdata", mem_wdata, 32'hCAFE_0001);
            if (k == 4) mem_ready = 1'b1;
        end
        tick();
        mem_ready = 1'b0;
        chk("wr_rvalid", rvalid, 2'b10);
        chk("wr_rdata", rdata, 32'h0);
        tick();

        // Timeout: memory never answers
        addr     = {32'h0, 32'h0000_0080};
        req      = 2'b01;
        busy_cnt = 0;
        seen     = 1'b0;
        for (int k = 0; k < 40 && !seen; k++) begin
            tick();
            if (k == 0) req = 2'b00;
            if (mem_en) busy_cnt++;
            if (rvalid != 2'b00) begin
                seen = 1'b1;
                chk("to_rvalid", rvalid, 2'b01);
                chk("to_rdata", rdata, 32'h0);
                chk("to_err", timeout_err, 1'b1);
            end
        end
        chk("to_rvalid_seen", seen, 1'b1);
        chk("to_busy_cycles", busy_cnt, 15);
        tick();
        tick();
        tick();
        chk("to_err_sticky", timeout_err, 1'b1);
        do_reset();
        chk("to_err_cleared", timeout_err, 1'b0);
        tick();

        // Ready on the 15th BUSY cycle completes normally
        mem_rdata = 32'h0BAD_F00D;
        req       = 2'b01;
        tick();
        req = 2'b00;
        for (int k = 2; k <= 15; k++) begin
            tick();
            if (k == 15) mem_ready = 1'b1;
        end
        tick();
        mem_ready = 1'b0;
        chk("edge_rvalid", rvalid, 2'b01);
        chk("edge_rdata", rdata, 32'h0BAD_F00D);
        chk("edge_err", timeout_err, 1'b0);
        tick();

        // Reset in BUSY aborts without rvalid; loader granted after release
        req = 2'b01;
        tick();
        req = 2'b00;
        tick();
        #1 reset = 1'b0;
        #1;
        chk("arst_mem_en", mem_en, 1'b0);
        chk("arst_rvalid", rvalid, 2'b00);
        tick();
        tick();
        reset = 1'b1;
        req   = 2'b10;
        we    = 2'b00;
        tick();
        chk("arst_ldr_gnt", gnt, 2'b10);
        req       = 2'b00;
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("arst_ldr_rvalid", rvalid, 2'b10);
        tick();
        tick();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
